simon: RTL and testbench
========================

SIMON -- requirements
Module: simon

Interface
REQ-001 pclk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-low reset; sampled on rising pclk edge.
REQ-003 level  input  1  difficulty: 1 = hard (any 4-bit pattern legal), 0 = easy (one-hot patterns only); sampled only during reset.
REQ-004 pattern  input  4  player switch value.
REQ-005 pattern_leds  output  4  combinational display of the switches or the stored sequence, per mode.
REQ-006 mode_leds  output  3  combinational mode indicator: INPUT=001, PLAYBACK=010, REPEAT=100, DONE=111.

Function
REQ-007 State: mode (4 states), sequence memory of 64 x 4 bits, length count (0..64), index idx (0..63), latched level bit.
REQ-008 Memory read is asynchronous: mem[idx] is visible on pattern_leds in the same cycle idx changes.
REQ-009 INPUT: pattern_leds = pattern. On an edge with a legal pattern: mem[count] <= pattern, count <= count+1, idx <= 0, mode <= PLAYBACK.
REQ-010 INPUT, easy level, pattern not one-hot (including 0000): no store; mode stays INPUT.
REQ-011 PLAYBACK: pattern_leds = mem[idx]; switches are ignored. On an edge: if idx == count-1 then idx <= 0 and mode <= REPEAT; otherwise idx <= idx+1.
REQ-012 REPEAT: pattern_leds = pattern. On an edge, if pattern == mem[idx]:
- idx == count-1 and count < 64: idx <= 0, mode <= INPUT.
- idx == count-1 and count == 64: idx <= 0, mode <= DONE (memory full, game won).
- otherwise: idx <= idx+1.
REQ-013 REPEAT, pattern != mem[idx] on an edge: idx <= 0, mode <= DONE.
REQ-014 The level restriction does not apply to REPEAT guesses; comparison is exact over all 4 bits.
REQ-015 DONE: pattern_leds = mem[idx]. On each edge, idx <= idx+1, wrapping to 0 after count-1. The sequence cycles indefinitely; only reset leaves DONE.
REQ-016 Each mode transition takes effect at the edge; mode_leds reflect the new mode immediately after it.
REQ-017 A change on the level input outside reset has no effect for the rest of the game.

Reset
REQ-018 rst=0 at an edge: mode <= INPUT, count <= 0, idx <= 0, latched level <= level. Memory contents are not cleared.
REQ-019 Reset overrides every mode, including mid-playback, mid-repeat and DONE.
REQ-020 After reset: mode_leds = 001 and pattern_leds = pattern.

Configuration
REQ-021 SIMON_LEVEL_EN defined: the easy-level one-hot restriction (REQ-010) is enforced.
REQ-022 SIMON_LEVEL_EN undefined: level is ignored and every pattern is legal in INPUT.

Structure
REQ-023 Package simon_pkg holds:
- the mode enum and the mode_leds encodings (001/010/100/111);
- constants MEM_DEPTH = 64, PATTERN_W = 4 and IDX_W = 6.
REQ-024 The sequence store is a sub-module simon_mem: 64x4, synchronous write, asynchronous read. The top level holds the controller FSM and the datapath counters and comparator.

Verification
REQ-025 Hard reset, input and repeat:
- level=1, rst=0, edge, then rst=1 -> mode_leds=001 and pattern_leds track the switches.
- pattern=0011, edge -> 010 with pattern_leds=0011 regardless of switches.
- edge -> 100.
- pattern=0011, edge -> 001.
REQ-026 Level change mid-game ignored: continuing REQ-025, level=0, pattern=1010, edge -> 010. Playback shows 0011 then 1010, then 100 on the next edge.
REQ-027 Correct guesses advance: repeat 0011, edge -> stays 100; 1010, edge -> 001.
REQ-028 Wrong guess and DONE:
- 3-entry sequence 0011/1010/1101; guesses 0011 then 1110 -> 111.
- pattern_leds then cycle 0011, 1010, 1101, 0011, ... one step per edge, independent of the switches.
REQ-029 Easy-level rejection (with SIMON_LEVEL_EN):
- reset with level=0; pattern=0110, edge -> stays 001 and count stays 0.
- pattern=0100, edge -> 010.
REQ-030 Reset mid-game: from DONE, rst=0, edge -> 001. A new 1-entry game then plays back the new value.

Source files
------------

// File: rtl/simon_pkg.sv
// simon_pkg: shared modes, LED encodings, sizes and pattern helpers for the SIMON game.
package simon_pkg;
    localparam int MEM_DEPTH = 64;
    localparam int PATTERN_W = 4;
    localparam int IDX_W     = 6;

    localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(MEM_DEPTH);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        M_INPUT,
        M_PLAYBACK,
        M_REPEAT,
        M_DONE
    } mode_e;

    localparam logic [2:0] LED_INPUT    = 3'b001;
    localparam logic [2:0] LED_PLAYBACK = 3'b010;
    localparam logic [2:0] LED_REPEAT   = 3'b100;
    localparam logic [2:0] LED_DONE     = 3'b111;

    function automatic logic [2:0] mode_led(input mode_e m);
        return m == M_INPUT    ? LED_INPUT    :
               m == M_PLAYBACK ? LED_PLAYBACK :
               m == M_REPEAT   ? LED_REPEAT   : LED_DONE;
    endfunction

    function automatic logic is_onehot(input logic [PATTERN_W-1:0] p);
        return p != '0 && (p & (p - PATTERN_W'(1))) == '0;
    endfunction
endpackage

// File: rtl/simon_mem.sv
// simon_mem: 64x4 sequence store, synchronous write and asynchronous read.
module simon_mem
    import simon_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [IDX_W-1:0]     waddr_i,
    input  logic [PATTERN_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]     raddr_i,
    output logic [PATTERN_W-1:0] rdata_o
);
    logic [PATTERN_W-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/simon.sv
// simon: memory-game controller (input, playback, repeat, done) with counters and comparator.
// Define SIMON_LEVEL_EN to enforce one-hot patterns at the easy level.
module simon
    import simon_pkg::*;
(
    input  logic                 pclk,
    input  logic                 rst,
    input  logic                 level,
    input  logic [PATTERN_W-1:0] pattern,
    output logic [PATTERN_W-1:0] pattern_leds,
    output logic [2:0]           mode_leds
);
    mode_e                mode_q, mode_d;
    logic [IDX_W:0]       count_q, count_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [PATTERN_W-1:0] rd_data;
    logic                 legal, last, we;

`ifdef SIMON_LEVEL_EN
    logic level_q;
    always_ff @(posedge pclk) begin
        if (!rst) level_q <= level;
    end
    assign legal = level_q || is_onehot(pattern);
`else
    logic unused_level;
    assign unused_level = level;
    assign legal = 1'b1;
`endif

    simon_mem u_mem (
        .clk_i   (pclk),
        .we_i    (we),
        .waddr_i (count_q[IDX_W-1:0]),
        .wdata_i (pattern),
        .raddr_i (idx_q),
        .rdata_o (rd_data)
    );

    // count is 1..64 whenever idx is walked, so count-1 never underflows here
    assign last = {1'b0, idx_q} == count_q - CNT_ONE;

    always_comb begin
        mode_d  = mode_q;
        count_d = count_q;
        idx_d   = idx_q;
        we      = 1'b0;
        case (mode_q)
            M_INPUT: begin
                if (legal) begin
                    we      = 1'b1;
                    count_d = count_q + CNT_ONE;
                    idx_d   = '0;
                    mode_d  = M_PLAYBACK;
                end
            end
            M_PLAYBACK: begin
                idx_d  = last ? '0 : idx_q + IDX_ONE;
                mode_d = last ? M_REPEAT : M_PLAYBACK;
            end
            M_REPEAT: begin
                if (pattern != rd_data) begin
                    idx_d  = '0;
                    mode_d = M_DONE;
                end else if (last) begin
                    idx_d  = '0;
                    mode_d = count_q == CNT_FULL ? M_DONE : M_INPUT;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            M_DONE: idx_d = last ? '0 : idx_q + IDX_ONE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            mode_q  <= M_INPUT;
            count_q <= '0;
            idx_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            count_q <= count_d;
            idx_q   <= idx_d;
        end
    end

    assign pattern_leds = (mode_q == M_PLAYBACK || mode_q == M_DONE) ? rd_data : pattern;
    assign mode_leds    = mode_led(mode_q);
endmodule

// File: tb/tb_simon.sv
// tb_simon: scoreboard bench for simon; each row is {rst, pattern, expected mode_leds, expected pattern_leds}.
module tb_simon;
    logic       pclk = 1'b0;
    logic       rst = 1'b0;
    logic       level = 1'b1;
    logic [3:0] pattern = 4'b0000;
    logic [3:0] pattern_leds;
    logic [2:0] mode_leds;
    int         checks = 0;
    int         errors = 0;

    typedef struct packed {
        logic       r;
        logic [3:0] p;
        logic [2:0] m;
        logic [3:0] l;
    } step_t;

    step_t sb[$];

    simon dut (
        .pclk         (pclk),
        .rst          (rst),
        .level        (level),
        .pattern      (pattern),
        .pattern_leds (pattern_leds),
        .mode_leds    (mode_leds)
    );

    always #5 pclk = ~pclk;

    task automatic test_reset();
        logic [11:0] tbl [2] = '{12'b0_0101_001_0101, 12'b0_1111_001_1111};
        step_t s, e;
        level = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s = step_t'(tbl[i]);
            rst = s.r;
            pattern = s.p;
            sb.push_back(s);
            @(posedge pclk);
            #1;
            e = sb.pop_front();
            checks++;
            if (mode_leds !== e.m || pattern_leds !== e.l) begin
                errors++;
                $display("FAIL reset row %0d: mode_leds=%b pattern_leds=%b, expected %b %b", i, mode_leds, pattern_leds, e.m, e.l);
            end
        end
    endtask

    task automatic test_hard_input_repeat();
        logic [11:0] tbl [9] = '{
            12'b0_0000_001_0000, 12'b1_0011_010_0011, 12'b1_1111_100_1111,
            12'b1_0011_001_0011, 12'b1_1010_010_0011, 12'b1_0000_010_1010,
            12'b1_0000_100_0000, 12'b1_0011_100_0011, 12'b1_1010_001_1010};
        step_t s, e;
        level = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i == 1) level = 1'b0;
            s = step_t'(tbl[i]);
            rst = s.r;
            pattern = s.p;
            sb.push_back(s);
            @(posedge pclk);
            #1;
            e = sb.pop_front();
            checks++;
            if (mode_leds !== e.m || pattern_leds !== e.l) begin
                errors++;
                $display("FAIL hard_input_repeat row %0d: mode_leds=%b pattern_leds=%b, expected %b %b", i, mode_leds, pattern_leds, e.m, e.l);
            end
        end
    endtask

    task automatic test_wrong_guess_done();
        logic [11:0] tbl [19] = '{
            12'b0_0000_001_0000, 12'b1_0011_010_0011, 12'b1_0000_100_0000,
            12'b1_0011_001_0011, 12'b1_1010_010_0011, 12'b1_0000_010_1010,
            12'b1_0000_100_0000, 12'b1_0011_100_0011, 12'b1_1010_001_1010,
            12'b1_1101_010_0011, 12'b1_0000_010_1010, 12'b1_0000_010_1101,
            12'b1_0000_100_0000, 12'b1_0011_100_0011, 12'b1_1110_111_0011,
            12'b1_0101_111_1010, 12'b1_1111_111_1101, 12'b1_0000_111_0011,
            12'b1_1110_111_1010};
        step_t s, e;
        level = 1'b1;
        for (int i = 0; i < 19; i++) begin
            s = step_t'(tbl[i]);
            rst = s.r;
            pattern = s.p;
            sb.push_back(s);
            @(posedge pclk);
            #1;
            e = sb.pop_front();
            checks++;
            if (mode_leds !== e.m || pattern_leds !== e.l) begin
                errors++;
                $display("FAIL wrong_guess_done row %0d: mode_leds=%b pattern_leds=%b, expected %b %b", i, mode_leds, pattern_leds, e.m, e.l);
            end
        end
    endtask

    task automatic test_reset_mid_game();
        logic [11:0] tbl [9] = '{
            12'b0_0110_001_0110, 12'b1_1001_010_1001, 12'b1_0000_100_0000,
            12'b0_0101_001_0101, 12'b1_0101_010_0101, 12'b0_0010_001_0010,
            12'b1_1000_010_1000, 12'b1_0000_100_0000, 12'b1_1000_001_1000};
        step_t s, e;
        level = 1'b1;
        for (int i = 0; i < 9; i++) begin
            s = step_t'(tbl[i]);
            rst = s.r;
            pattern = s.p;
            sb.push_back(s);
            @(posedge pclk);
            #1;
            e = sb.pop_front();
            checks++;
            if (mode_leds !== e.m || pattern_leds !== e.l) begin
                errors++;
                $display("FAIL reset_mid_game row %0d: mode_leds=%b pattern_leds=%b, expected %b %b", i, mode_leds, pattern_leds, e.m, e.l);
            end
        end
    endtask

    task automatic test_easy_level();
`ifdef SIMON_LEVEL_EN
        logic [11:0] tbl [7] = '{
            12'b0_0000_001_0000, 12'b1_0110_001_0110, 12'b1_0000_001_0000,
            12'b1_0100_010_0100, 12'b1_0000_100_0000, 12'b1_0100_001_0100,
            12'b1_0110_001_0110};
`else
        logic [11:0] tbl [4] = '{
            12'b0_0000_001_0000, 12'b1_0110_010_0110, 12'b1_0000_100_0000,
            12'b1_0110_001_0110};
`endif
        step_t s, e;
        level = 1'b0;
        for (int i = 0; i < $size(tbl); i++) begin
            if (i == 6) level = 1'b1;
            s = step_t'(tbl[i]);
            rst = s.r;
            pattern = s.p;
            sb.push_back(s);
            @(posedge pclk);
            #1;
            e = sb.pop_front();
            checks++;
            if (mode_leds !== e.m || pattern_leds !== e.l) begin
                errors++;
                $display("FAIL easy_level row %0d: mode_leds=%b pattern_leds=%b, expected %b %b", i, mode_leds, pattern_leds, e.m, e.l);
            end
        end
    endtask

    task automatic test_full_memory();
        logic [3:0] pat [64];
        logic [3:0] r;
        step_t      q[$];
        step_t      s, e;
        level = 1'b1;
        foreach (pat[i]) pat[i] = 4'($urandom);
        q.push_back({1'b0, 4'b0000, 3'b001, 4'b0000});
        for (int n = 0; n < 64; n++) begin
            q.push_back({1'b1, pat[n], 3'b010, pat[0]});
            for (int k = 0; k <= n; k++) begin
                r = 4'($urandom);
                q.push_back({1'b1, r, k < n ? 3'b010 : 3'b100, k < n ? pat[k+1] : r});
            end
            for (int k = 0; k <= n; k++)
                q.push_back({1'b1, pat[k], k < n ? 3'b100 : (n < 63 ? 3'b001 : 3'b111),
                             (k == n && n == 63) ? pat[0] : pat[k]});
        end
        for (int j = 0; j < 65; j++) begin
            r = 4'($urandom);
            q.push_back({1'b1, r, 3'b111, pat[(j+1)%64]});
        end
        for (int i = 0; i < q.size(); i++) begin
            s = q[i];
            rst = s.r;
            pattern = s.p;
            sb.push_back(s);
            @(posedge pclk);
            #1;
            e = sb.pop_front();
            checks++;
            if (mode_leds !== e.m || pattern_leds !== e.l) begin
                errors++;
                $display("FAIL full_memory step %0d: mode_leds=%b pattern_leds=%b, expected %b %b", i, mode_leds, pattern_leds, e.m, e.l);
            end
        end
    endtask

    initial begin
        @(posedge pclk);
        #1;
        test_reset();
        test_hard_input_repeat();
        test_wrong_guess_done();
        test_reset_mid_game();
        test_easy_level();
        test_full_memory();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
